// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - program counter sequencer with branch, call/return and a LIFO return stack
module prog_sequencer #(
  parameter int D           = 12,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic                               branch_en,
  input  logic                               reljump_en,
  input  logic                               absjump_en,
  input  logic                               call_en,
  input  logic                               ret_en,
  input  logic [D-1:0]                       target,
  output logic [D-1:0]                       prog_ctr,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               overflow_err,
  output logic                               underflow_err
);

  localparam int SW = $clog2(STACK_DEPTH + 1);
  localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SW-1:0] FULL_DEPTH = SW'(STACK_DEPTH);

  // Sized to a power of two so any AW-bit index stays in range.
  logic [D-1:0]  stack_mem [2**AW];
  logic [D-1:0]  pc_inc;
  logic [AW-1:0] push_idx;
  logic [AW-1:0] top_idx;

  assign pc_inc      = prog_ctr + D'(1);
  assign push_idx    = AW'(stack_depth);
  assign top_idx     = AW'(stack_depth - SW'(1));
  assign stack_full  = (stack_depth == FULL_DEPTH);
  assign stack_empty = (stack_depth == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      prog_ctr      <= D'(RESET_ADDR);
      stack_depth   <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (stall) begin
      prog_ctr <= prog_ctr;
    end else if (ret_en) begin
      // A simultaneous call is dropped silently; return has priority.
      if (!stack_empty) begin
        prog_ctr    <= stack_mem[top_idx];
        stack_depth <= stack_depth - SW'(1);
      end else begin
        underflow_err <= 1'b1;
        prog_ctr      <= pc_inc;
      end
    end else if (call_en) begin
      if (!stack_full) begin
        stack_mem[push_idx] <= pc_inc;
        stack_depth         <= stack_depth + SW'(1);
        prog_ctr            <= target;
      end else begin
        overflow_err <= 1'b1;
        prog_ctr     <= pc_inc;
      end
    end else if (branch_en && reljump_en) begin
      prog_ctr <= prog_ctr + target;
    end else if (branch_en && absjump_en) begin
      prog_ctr <= target;
    end else begin
      prog_ctr <= pc_inc;
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - self-checking bench for prog_sequencer
module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic        reljump_en = 1'b0;
  logic        absjump_en = 1'b0;
  logic        call_en = 1'b0;
  logic        ret_en = 1'b0;
  logic [11:0] target = '0;
  logic [11:0] prog_ctr;
  logic [2:0]  stack_depth;
  logic        stack_full;
  logic        stack_empty;
  logic        overflow_err;
  logic        underflow_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] pc;
    logic [2:0]  depth;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sbq[$];
  logic [11:0] m_pc = '0;
  logic [11:0] m_stk[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  prog_sequencer #(.D(12), .STACK_DEPTH(4), .RESET_ADDR(0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
    .reljump_en(reljump_en), .absjump_en(absjump_en), .call_en(call_en),
    .ret_en(ret_en), .target(target), .prog_ctr(prog_ctr),
    .stack_depth(stack_depth), .stack_full(stack_full),
    .stack_empty(stack_empty), .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of requests, advance the model, then compare after the edge.
  task automatic step(input logic rst, input logic st, input logic br, input logic rel,
                      input logic abs_j, input logic cl, input logic rt, input logic [11:0] tg);
    exp_t e;
    reset = rst; stall = st; branch_en = br; reljump_en = rel;
    absjump_en = abs_j; call_en = cl; ret_en = rt; target = tg;
    if (rst) begin
      m_pc = 12'h000; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (st) begin
      m_pc = m_pc;
    end else if (rt) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_unf = 1'b1; m_pc = 12'(m_pc + 12'd1); end
    end else if (cl) begin
      if (m_stk.size() < 4) begin m_stk.push_back(12'(m_pc + 12'd1)); m_pc = tg; end
      else begin m_ovf = 1'b1; m_pc = 12'(m_pc + 12'd1); end
    end else if (br && rel) begin
      m_pc = 12'(m_pc + tg);
    end else if (br && abs_j) begin
      m_pc = tg;
    end else begin
      m_pc = 12'(m_pc + 12'd1);
    end
    e.pc = m_pc; e.depth = 3'(m_stk.size()); e.ovf = m_ovf; e.unf = m_unf;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("prog_ctr", 32'(prog_ctr), 32'(e.pc));
    chk("stack_depth", 32'(stack_depth), 32'(e.depth));
    chk("stack_full", 32'(stack_full), 32'(e.depth == 3'd4));
    chk("stack_empty", 32'(stack_empty), 32'(e.depth == 3'd0));
    chk("overflow_err", 32'(overflow_err), 32'(e.ovf));
    chk("underflow_err", 32'(underflow_err), 32'(e.unf));
    reset = 1'b0; stall = 1'b0; branch_en = 1'b0; reljump_en = 1'b0;
    absjump_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
  endtask

  task automatic idle();       step(0, 0, 0, 0, 0, 0, 0, 12'h000); endtask
  task automatic jabs(input logic [11:0] t); step(0, 0, 1, 0, 1, 0, 0, t); endtask
  task automatic jrel(input logic [11:0] t); step(0, 0, 1, 1, 0, 0, 0, t); endtask
  task automatic call(input logic [11:0] t); step(0, 0, 0, 0, 0, 1, 0, t); endtask
  task automatic ret();        step(0, 0, 0, 0, 0, 0, 1, 12'h000); endtask
  task automatic rst(input logic st); step(1, st, 0, 0, 0, 1, 1, 12'h555); endtask

  initial begin
    @(negedge clk);
    rst(1'b0);
    chk("reset_pc", 32'(prog_ctr), 32'h000);
    idle(); idle(); idle();
    chk("idle3_pc", 32'(prog_ctr), 32'h003);

    jabs(12'hFFF);
    idle();
    chk("wrap_pc", 32'(prog_ctr), 32'h000);

    jabs(12'h010);
    jrel(12'hFFC);
    chk("rel_pc", 32'(prog_ctr), 32'h00C);
    step(0, 0, 1, 1, 1, 0, 0, 12'h004);
    chk("rel_wins_pc", 32'(prog_ctr), 32'h010);
    jabs(12'h200);
    chk("abs_pc", 32'(prog_ctr), 32'h200);
    step(0, 0, 1, 0, 0, 0, 0, 12'h7AA);
    chk("branch_noselect_pc", 32'(prog_ctr), 32'h201);

    jabs(12'h020);
    call(12'h100);
    jabs(12'h105);
    call(12'h300);
    chk("nested_depth", 32'(stack_depth), 32'd2);
    ret();
    chk("ret1_pc", 32'(prog_ctr), 32'h106);
    ret();
    chk("ret2_pc", 32'(prog_ctr), 32'h021);
    chk("ret2_empty", 32'(stack_empty), 32'd1);

    jabs(12'h3F0);
    for (int i = 0; i < 5; i++) call(12'(12'h400 + 12'(i * 16)));
    chk("ovf_flag", 32'(overflow_err), 32'd1);
    chk("ovf_pc", 32'(prog_ctr), 32'h431);
    chk("ovf_depth", 32'(stack_depth), 32'd4);
    for (int i = 0; i < 4; i++) ret();
    chk("unwind_pc", 32'(prog_ctr), 32'h3F1);
    ret();
    chk("unf_flag", 32'(underflow_err), 32'd1);
    chk("unf_pc", 32'(prog_ctr), 32'h3F2);
    call(12'h0AB);
    chk("sticky_ovf", 32'(overflow_err), 32'd1);

    rst(1'b0);
    jabs(12'h050);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1, 0, 12'h600);
    chk("stall_pc", 32'(prog_ctr), 32'h050);
    chk("stall_depth", 32'(stack_depth), 32'd0);
    idle();
    call(12'h700);
    step(0, 0, 0, 0, 0, 1, 1, 12'h7F0);
    chk("callret_pc", 32'(prog_ctr), 32'h052);
    chk("callret_depth", 32'(stack_depth), 32'd0);
    chk("callret_noerr", 32'({overflow_err, underflow_err}), 32'd0);

    for (int i = 0; i < 5; i++) call(12'(12'h800 + 12'(i)));
    ret();
    chk("pre_reset_depth", 32'(stack_depth), 32'd3);
    rst(1'b1);
    chk("rst_stall_pc", 32'(prog_ctr), 32'h000);
    chk("rst_stall_depth", 32'(stack_depth), 32'd0);
    chk("rst_stall_flags", 32'({overflow_err, underflow_err}), 32'd0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
